// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, oversampling edge/bit counters,
// LSB-first deserializer, parity and stop checking.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic                  dat_samp_en,
  output logic [5:0]            edge_count,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_nxt;
  logic [5:0]            presc_l;
  logic                  par_en_l, par_typ_l;
  logic [BCW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt, p_data_nxt;
  logic [5:0]            edge_nxt;
  logic                  dv_nxt, par_err_nxt, stp_err_nxt, latch_cfg;
  logic                  bit_end;

  function automatic logic parity_exp(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return odd ? ~^d : ^d;
  endfunction

  assign bit_end = (edge_count == presc_l - 6'd1);

  always_comb begin
    state_nxt   = state;
    edge_nxt    = edge_count;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    p_data_nxt  = P_DATA;
    dv_nxt      = 1'b0;
    par_err_nxt = par_err;
    stp_err_nxt = stp_err;
    latch_cfg   = 1'b0;
    dat_samp_en = (state != IDLE);
    if (state != IDLE) edge_nxt = bit_end ? 6'd0 : edge_count + 6'd1;
    case (state)
      IDLE: begin
        edge_nxt = 6'd0;
        if (!RX_IN) begin
          state_nxt   = START;
          latch_cfg   = 1'b1;
          par_err_nxt = 1'b0;
          stp_err_nxt = 1'b0;
        end
      end
      START: begin
        // a start bit that votes high was line noise: drop it silently
        if (bit_end) begin
          if (!sampled_bit) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt   = {sampled_bit, shift[DATA_WIDTH-1:1]};
          bit_cnt_nxt = bit_cnt + BCW'(1);
          if (bit_cnt == BCW'(DATA_WIDTH - 1)) state_nxt = par_en_l ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_err_nxt = (sampled_bit != parity_exp(shift, par_typ_l));
          state_nxt   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          stp_err_nxt = ~sampled_bit;
          if (sampled_bit && !par_err) begin
            p_data_nxt = shift;
            dv_nxt     = 1'b1;
          end
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      edge_count <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      presc_l    <= '0;
      par_en_l   <= 1'b0;
      par_typ_l  <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      edge_count <= edge_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shift      <= shift_nxt;
      P_DATA     <= p_data_nxt;
      data_valid <= dv_nxt;
      par_err    <= par_err_nxt;
      stp_err    <= stp_err_nxt;
      if (latch_cfg) begin
        presc_l   <= Prescale;
        par_en_l  <= PAR_EN;
        par_typ_l <= PAR_TYP;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: serial frames on RX_IN, a mid-bit
// sampler stand-in, and a frame-level reference model with a pulse scoreboard.
module tb_uart_rx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       sampled_bit;
  logic       dat_samp_en;
  logic [5:0] edge_count;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int tb_presc = 8;
  int busy_until = 0;

  int         dv_t[$];
  logic [7:0] dv_d[$];
  int         exp_t[$];
  logic [7:0] exp_d[$];
  logic [7:0] m_pdata = 8'h00;
  logic       m_par_err = 1'b0;
  logic       m_stp_err = 1'b0;

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit), .dat_samp_en(dat_samp_en),
    .edge_count(edge_count), .P_DATA(P_DATA), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Sampler stand-in: takes the line at mid-bit, clears when disabled.
  always @(posedge CLK or negedge RST) begin
    if (!RST) sampled_bit <= 1'b0;
    else if (!dat_samp_en) sampled_bit <= 1'b0;
    else if (int'(edge_count) == tb_presc / 2) sampled_bit <= RX_IN;
  end

  always @(negedge CLK) begin
    if (data_valid === 1'b1) begin
      dv_t.push_back(cyc);
      dv_d.push_back(P_DATA);
    end
  end

  // Drives one frame; called at #1 after a rising edge. The model predicts
  // start detection (one cycle after the line falls, or one cycle after the
  // previous frame releases the receiver) and the pulse N*p edges later.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pe, input logic pt,
                            input logic flip, input logic stop_val, input int p_mid);
    int c, e0, n;
    logic pbit;
    c = cyc;
    tb_presc = p;
    Prescale = 6'(p);
    PAR_EN = pe;
    PAR_TYP = pt;
    pbit = (pt ? ~^d : ^d) ^ flip;
    e0 = (c + 1 > busy_until + 1) ? c + 1 : busy_until + 1;
    n = 10 + (pe ? 1 : 0);
    busy_until = e0 + n * p;
    m_par_err = pe && flip;
    m_stp_err = !stop_val;
    if (stop_val && !(pe && flip)) begin
      exp_t.push_back(busy_until);
      exp_d.push_back(d);
      m_pdata = d;
    end
    RX_IN = 1'b0;
    repeat (p) @(posedge CLK);
    #1;
    if (p_mid != 0) Prescale = 6'(p_mid);
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      repeat (p) @(posedge CLK);
      #1;
    end
    if (pe) begin
      RX_IN = pbit;
      repeat (p) @(posedge CLK);
      #1;
    end
    RX_IN = stop_val;
    repeat (p) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (dat_samp_en !== 1'b0 || edge_count !== 6'd0) begin
      failures++;
      $display("FAIL reset_ctrl got en=%b edge=%0d exp en=0 edge=0", dat_samp_en, edge_count);
    end
    checks++;
    if ({P_DATA, data_valid, par_err, stp_err} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs got P_DATA=%h dv=%b pe=%b se=%b exp all 0", P_DATA, data_valid, par_err, stp_err);
    end
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (dat_samp_en !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_en got=%b exp=0", dat_samp_en);
    end
  endtask

  task automatic test_basic_p8();
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (dv_t.size() != exp_t.size()) begin
      failures++;
      $display("FAIL basic_pulses got=%0d exp=%0d", dv_t.size(), exp_t.size());
    end else foreach (exp_t[i]) begin
      checks++;
      if (dv_t[i] !== exp_t[i] || dv_d[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL basic_dv[%0d] got t=%0d d=%h exp t=%0d d=%h", i, dv_t[i], dv_d[i], exp_t[i], exp_d[i]);
      end
    end
    checks++;
    if ({P_DATA, par_err, stp_err} !== {m_pdata, m_par_err, m_stp_err}) begin
      failures++;
      $display("FAIL basic_state got P_DATA=%h pe=%b se=%b exp %h %b %b", P_DATA, par_err, stp_err, m_pdata, m_par_err, m_stp_err);
    end
    dv_t.delete(); dv_d.delete(); exp_t.delete(); exp_d.delete();
  endtask

  task automatic test_parity();
    logic flips[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic stops[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] ds[4] = '{8'hA5, 8'hA5, 8'h3C, 8'h3C};
    int ps[4] = '{16, 16, 32, 32};
    logic pts[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      send_frame(ds[k], ps[k], 1'b1, pts[k], flips[k], stops[k], 0);
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if (dv_t.size() != exp_t.size()) begin
        failures++;
        $display("FAIL parity%0d_pulses got=%0d exp=%0d", k, dv_t.size(), exp_t.size());
      end else foreach (exp_t[i]) begin
        checks++;
        if (dv_t[i] !== exp_t[i] || dv_d[i] !== exp_d[i]) begin
          failures++;
          $display("FAIL parity%0d_dv got t=%0d d=%h exp t=%0d d=%h", k, dv_t[i], dv_d[i], exp_t[i], exp_d[i]);
        end
      end
      checks++;
      if ({P_DATA, par_err, stp_err} !== {m_pdata, m_par_err, m_stp_err}) begin
        failures++;
        $display("FAIL parity%0d_state got P_DATA=%h pe=%b se=%b exp %h %b %b", k, P_DATA, par_err, stp_err, m_pdata, m_par_err, m_stp_err);
      end
      dv_t.delete(); dv_d.delete(); exp_t.delete(); exp_d.delete();
      repeat (2) @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_glitch();
    tb_presc = 8;
    Prescale = 6'd8;
    PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    checks++;
    if (dat_samp_en !== 1'b1 || edge_count !== 6'd1) begin
      failures++;
      $display("FAIL glitch_start got en=%b edge=%0d exp en=1 edge=1", dat_samp_en, edge_count);
    end
    repeat (6) @(posedge CLK);
    #1;
    checks++;
    if (dat_samp_en !== 1'b1 || edge_count !== 6'd7) begin
      failures++;
      $display("FAIL glitch_bitend got en=%b edge=%0d exp en=1 edge=7", dat_samp_en, edge_count);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (dat_samp_en !== 1'b0 || edge_count !== 6'd0) begin
      failures++;
      $display("FAIL glitch_abort got en=%b edge=%0d exp en=0 edge=0", dat_samp_en, edge_count);
    end
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (dv_t.size() != 0 || par_err !== 1'b0 || stp_err !== 1'b0 || P_DATA !== m_pdata) begin
      failures++;
      $display("FAIL glitch_quiet got pulses=%0d pe=%b se=%b P_DATA=%h exp 0 0 0 %h", dv_t.size(), par_err, stp_err, P_DATA, m_pdata);
    end
    m_par_err = 1'b0;
    m_stp_err = 1'b0;
    dv_t.delete(); dv_d.delete();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    repeat (4) @(posedge CLK);
    #1;
    checks++;
    if (dv_t.size() != 2 || exp_t.size() != 2) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d exp=2", dv_t.size());
    end else foreach (exp_t[i]) begin
      checks++;
      if (dv_t[i] !== exp_t[i] || dv_d[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL b2b_dv[%0d] got t=%0d d=%h exp t=%0d d=%h", i, dv_t[i], dv_d[i], exp_t[i], exp_d[i]);
      end
    end
    dv_t.delete(); dv_d.delete(); exp_t.delete(); exp_d.delete();
  endtask

  task automatic test_reset_midframe();
    tb_presc = 8;
    Prescale = 6'd8;
    PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (8 * 3) @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if ({dat_samp_en, edge_count, P_DATA, data_valid, par_err, stp_err} !== 18'd0) begin
      failures++;
      $display("FAIL midreset_outputs got en=%b edge=%0d P_DATA=%h dv=%b pe=%b se=%b exp all 0",
               dat_samp_en, edge_count, P_DATA, data_valid, par_err, stp_err);
    end
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    m_pdata = 8'h00;
    busy_until = 0;
    dv_t.delete(); dv_d.delete(); exp_t.delete(); exp_d.delete();
    repeat (20) @(posedge CLK);
    #1;
    checks++;
    if (dat_samp_en !== 1'b0 || dv_t.size() != 0) begin
      failures++;
      $display("FAIL midreset_abandon got en=%b pulses=%0d exp en=0 pulses=0", dat_samp_en, dv_t.size());
    end
    send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b0, 1'b1, 8);
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (dv_t.size() != 1 || exp_t.size() != 1) begin
      failures++;
      $display("FAIL latch_pulses got=%0d exp=1", dv_t.size());
    end else begin
      checks++;
      if (dv_t[0] !== exp_t[0] || dv_d[0] !== exp_d[0]) begin
        failures++;
        $display("FAIL latch_dv got t=%0d d=%h exp t=%0d d=%h", dv_t[0], dv_d[0], exp_t[0], exp_d[0]);
      end
    end
    dv_t.delete(); dv_d.delete(); exp_t.delete(); exp_d.delete();
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int p;
      logic [7:0] d;
      logic pe, pt, fl, st;
      p  = 8 << $urandom_range(0, 2);
      d  = 8'($urandom);
      pe = 1'($urandom_range(0, 1));
      pt = 1'($urandom_range(0, 1));
      fl = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 4) != 0);
      send_frame(d, p, pe, pt, fl, st, 0);
      repeat (3) @(posedge CLK);
      #1;
      checks++;
      if (dv_t.size() != exp_t.size()) begin
        failures++;
        $display("FAIL rand%0d_pulses got=%0d exp=%0d", k, dv_t.size(), exp_t.size());
      end else foreach (exp_t[i]) begin
        checks++;
        if (dv_t[i] !== exp_t[i] || dv_d[i] !== exp_d[i]) begin
          failures++;
          $display("FAIL rand%0d_dv got t=%0d d=%h exp t=%0d d=%h", k, dv_t[i], dv_d[i], exp_t[i], exp_d[i]);
        end
      end
      checks++;
      if ({P_DATA, par_err, stp_err} !== {m_pdata, m_par_err, m_stp_err}) begin
        failures++;
        $display("FAIL rand%0d_state got P_DATA=%h pe=%b se=%b exp %h %b %b", k, P_DATA, par_err, stp_err, m_pdata, m_par_err, m_stp_err);
      end
      dv_t.delete(); dv_d.delete(); exp_t.delete(); exp_d.delete();
    end
  endtask

  initial begin
    test_reset();
    test_basic_p8();
    test_parity();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
